ft_tx_packetizer: RTL
=====================

// Module: ft_tx_packetizer
// PURPOSE
//  Upstream feeder for the synchronous FT245 interface in the ft_clkout domain.
//  Frames 16-bit CCD pixel words into a byte stream:
//    header A5 5A, 16-bit frame counter, then pixels MSB byte first.
//  Buffers the bytes in a show-ahead FIFO that drives data_to_ft / data_to_ft_avail
//  and pops on next_data_to_ft. The readout side sees a valid/ready handshake.
// PARAMETERS
//  AW          9      FIFO address width; depth = 2**AW bytes (512)
//  HDR0        8'hA5  first header byte
//  HDR1        8'h5A  second header byte
// PORTS
//  ft_clkout        in   1      single clock; everything samples posedge
//  rst_n            in   1      asynchronous active-low reset
//  frame_start      in   1      1-cycle pulse: begin a new frame
//  frame_end        in   1      1-cycle pulse: close the current frame
//  pix_data         in   16     pixel word
//  pix_valid        in   1      pix_data valid
//  pix_ready        out  1      packetizer accepts pix_data this cycle
//  data_to_ft       out  8      byte at FIFO head (show-ahead)
//  data_to_ft_avail out  1      FIFO not empty
//  next_data_to_ft  in   1      pop request from FT245 stage
//  fifo_level       out  AW+1   bytes currently stored, 0..2**AW
//  frame_active     out  1      high from HDR0 entry until return to IDLE
//  proto_err        out  1      sticky: frame_start seen while not IDLE
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - FIFO pointers 0; state IDLE; frame_cnt 0; lo_hold 0; end_pend 0; proto_err 0.
//   - Outputs: pix_ready=0, data_to_ft_avail=0, fifo_level=0, frame_active=0.
//   - data_to_ft is don't-care while empty; the bench checks it only when avail=1.
//  FIFO:
//   - Pointers are AW+1 bits. full = MSBs differ and address bits equal; empty = ptrs equal.
//   - push = wr_en && !full. pop = next_data_to_ft && !empty.
//   - Push and pop in the same cycle are both legal; level is unchanged.
//   - Push when full: never issued by the FSM, since every write waits for !full.
//     Full is evaluated before any same-cycle pop.
//   - Pop when empty: ignored; pointers and level unchanged.
//   - data_to_ft = mem[rd_ptr]. After a pop, the next byte appears the following cycle.
//  FSM (one FIFO write per cycle max; every write state holds while full):
//   - IDLE: pix_ready=0. frame_start -> HDR0.
//   - HDR0: write HDR0 -> HDR1.
//   - HDR1: write HDR1 -> CNT_H.
//   - CNT_H: write frame_cnt[15:8] -> CNT_L.
//   - CNT_L: write frame_cnt[7:0]; frame_cnt <= frame_cnt+1, wrapping FFFF -> 0000; -> PIX.
//   - PIX: pix_ready = !full.
//       - On pix_valid && pix_ready: write pix_data[15:8], lo_hold <= pix_data[7:0], -> LO.
//       - Else if frame_end: -> IDLE.
//   - LO: pix_ready=0. Write lo_hold.
//       - -> IDLE if end_pend, else -> PIX.
//       - Clear end_pend on leaving.
//  Boundary cases:
//   - frame_end coinciding with a pixel accept in PIX: the pixel is kept, end_pend <= 1,
//     and the frame closes after the LO write.
//   - frame_end in LO: sets end_pend.
//   - frame_end in the HDR0..CNT_L states: sets end_pend. PIX then exits to IDLE at once
//     (a zero-pixel frame).
//   - frame_end in IDLE: ignored.
//   - frame_start outside IDLE: ignored; proto_err <= 1.
//   - frame_start and frame_end together in IDLE: the frame starts and end_pend is set.
//  Latency: a pixel accepted at cycle t has its MSB visible at data_to_ft by t+1
//   if the FIFO was empty.
//  Throughput: 1 byte/cycle in; a pixel every 2 cycles when not stalled.
// TESTING
//  1. Reset mid-frame (state PIX, level 37):
//     -> next cycle level=0, avail=0, pix_ready=0, frame_active=0, proto_err=0.
//  2. frame_start; 3 pixels 1234,ABCD,00FF; frame_end; next_data_to_ft held 1
//     -> bytes A5 5A 00 00 12 34 AB CD 00 FF, in order, none duplicated.
//  3. Second frame after test 2 -> counter bytes 00 01.
//     Force frame_cnt=FFFF -> bytes FF FF, then the next frame sends 00 00.
//  4. Pop held 0; stream 300 pixels -> level saturates at 512 and pix_ready deasserts.
//     No byte lost; after draining, all 604 bytes match.
//  5. frame_end on the same cycle as a pixel accept
//     -> both pixel bytes are written, then IDLE; frame_active falls after LO.
//  6. frame_start pulsed in PIX -> proto_err=1 (sticky); stream unchanged.
//     next_data_to_ft while empty -> level stays 0.

Source files
------------

// File: rtl/ft_tx_packetizer_if.sv
// Pixel handshake and FT245-side byte stream bundle.
// slave = packetizer, master = pixel source plus FT245 consumer.
interface ft_tx_packetizer_if;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  data_to_ft;
  logic        data_to_ft_avail;
  logic        next_data_to_ft;

  modport slave (
    input  pix_data,
    input  pix_valid,
    output pix_ready,
    output data_to_ft,
    output data_to_ft_avail,
    input  next_data_to_ft
  );

  modport master (
    output pix_data,
    output pix_valid,
    input  pix_ready,
    input  data_to_ft,
    input  data_to_ft_avail,
    output next_data_to_ft
  );
endinterface

// File: rtl/ft_tx_packetizer.sv
// Frames 16-bit CCD pixels into A5 5A / counter / pixel bytes
// and buffers them in a show-ahead FIFO for the FT245 stage.
module ft_tx_packetizer #(
  parameter int         AW   = 9,
  parameter logic [7:0] HDR0 = 8'hA5,
  parameter logic [7:0] HDR1 = 8'h5A
) (
  input  logic                 ft_clkout,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 frame_end,
  ft_tx_packetizer_if.slave    bus,
  output logic [AW:0]          fifo_level,
  output logic                 frame_active,
  output logic                 proto_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR0 = 3'd1;
  localparam logic [2:0] ST_HDR1 = 3'd2;
  localparam logic [2:0] ST_CNTH = 3'd3;
  localparam logic [2:0] ST_CNTL = 3'd4;
  localparam logic [2:0] ST_PIX  = 3'd5;
  localparam logic [2:0] ST_LO   = 3'd6;

  logic [7:0]  mem [2**AW];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        push;
  logic        pop;

  logic [2:0]  state;
  logic [15:0] frame_cnt;
  logic [7:0]  lo_hold;
  logic        end_pend;
  logic        accept;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = wr_en && !full;
  assign pop   = bus.next_data_to_ft && !empty;

  assign bus.data_to_ft       = mem[rd_ptr[AW-1:0]];
  assign bus.data_to_ft_avail = !empty;
  assign fifo_level           = wr_ptr - rd_ptr;
  assign frame_active         = (state != ST_IDLE);

  // A pending close from the header phase wins over new pixels.
  assign accept = bus.pix_valid && bus.pix_ready;

  always_comb begin
    wr_en         = 1'b0;
    wr_data       = 8'h00;
    bus.pix_ready = 1'b0;
    unique case (1'b1)
      (state == ST_HDR0): begin
        wr_en   = 1'b1;
        wr_data = HDR0;
      end
      (state == ST_HDR1): begin
        wr_en   = 1'b1;
        wr_data = HDR1;
      end
      (state == ST_CNTH): begin
        wr_en   = 1'b1;
        wr_data = frame_cnt[15:8];
      end
      (state == ST_CNTL): begin
        wr_en   = 1'b1;
        wr_data = frame_cnt[7:0];
      end
      (state == ST_PIX): begin
        bus.pix_ready = !full && !end_pend;
        wr_en         = bus.pix_valid && !full && !end_pend;
        wr_data       = bus.pix_data[15:8];
      end
      (state == ST_LO): begin
        wr_en   = 1'b1;
        wr_data = lo_hold;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ft_clkout) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge ft_clkout or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge ft_clkout or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
    end else if (frame_start && state != ST_IDLE) begin
      proto_err <= 1'b1;
    end
  end

  always_ff @(posedge ft_clkout or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      frame_cnt <= '0;
      lo_hold   <= '0;
      end_pend  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (frame_start) begin
            state    <= ST_HDR0;
            end_pend <= frame_end;
          end
        end
        (state == ST_HDR0),
        (state == ST_HDR1),
        (state == ST_CNTH),
        (state == ST_CNTL): begin
          if (frame_end) end_pend <= 1'b1;
          if (!full) begin
            state <= state + 3'd1;
            if (state == ST_CNTL) frame_cnt <= frame_cnt + 16'd1;
          end
        end
        (state == ST_PIX): begin
          if (accept) begin
            lo_hold <= bus.pix_data[7:0];
            state   <= ST_LO;
            if (frame_end) end_pend <= 1'b1;
          end else if (frame_end || end_pend) begin
            state    <= ST_IDLE;
            end_pend <= 1'b0;
          end
        end
        (state == ST_LO): begin
          if (!full) begin
            state    <= (end_pend || frame_end) ? ST_IDLE : ST_PIX;
            end_pend <= 1'b0;
          end else if (frame_end) begin
            end_pend <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
